// File: rtl/fifo_thresh_pkg.sv
// Shared definitions for the threshold FIFO: pointer-width macro, default
// flag margins and the registered status-flag bundle.
`ifndef FIFO_THRESH_DEFS
`define FIFO_THRESH_DEFS
`define CLOG2(x) $clog2(x)
`endif

package fifo_thresh_pkg;

  // almost_full defaults to this many entries below full
  localparam int AF_MARGIN  = 4;
  // almost_empty defaults to this many entries or fewer
  localparam int AE_DEFAULT = 4;

  // Status flags that are registered from the next-state count
  typedef struct packed {
    logic full;
    logic almost_full;
    logic data_available;
    logic almost_empty;
  } flags_t;

  // Empty FIFO: only almost_empty is asserted
  localparam flags_t FLAGS_RESET = '{full: 1'b0, almost_full: 1'b0,
                                     data_available: 1'b0, almost_empty: 1'b1};

endpackage

// File: rtl/fifo_thresh_if.sv
// Bus bundle between a FIFO user (master) and the FIFO (slave).
//
// Handshake: there is no ready signal. A write is taken on a rising clk edge
// when write_strobe is 1 and the FIFO has room (or a read is taken on the same
// edge); otherwise the word is dropped and overflow latches. A read is taken
// when read_strobe is 1 and level != 0; otherwise underflow latches. flush
// wins over both strobes on the same edge. read_valid qualifies read_data.
interface fifo_thresh_if #(
  parameter int WIDTH = 8,
  parameter int BITS  = 8
);
  logic              flush;
  logic [WIDTH-1:0]  write_data;
  logic              write_strobe;
  logic              full;
  logic              almost_full;
  logic              read_strobe;
  logic [WIDTH-1:0]  read_data;
  logic              read_valid;
  logic              data_available;
  logic              almost_empty;
  logic [BITS:0]     level;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, write_data, write_strobe, read_strobe,
    input  full, almost_full, read_data, read_valid, data_available,
           almost_empty, level, overflow, underflow
  );

  modport slave (
    input  flush, write_data, write_strobe, read_strobe,
    output full, almost_full, read_data, read_valid, data_available,
           almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_thresh_ram.sv
// Simple dual-port storage: one synchronous write port, one synchronous
// read port with registered output. Contents and output are never reset.
// A read and write to the same address on one edge returns the old word.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int NUM   = 256,
  parameter int BITS  = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [BITS-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [BITS-1:0]  raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [NUM];
  logic [WIDTH-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read port: output register holds when not enabled
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_thresh.sv
// Synchronous FIFO with almost-full / almost-empty thresholds, sticky error
// flags, flush, and either first-word-fallthrough or registered read data.
module fifo_thresh
  import fifo_thresh_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM      = 256,
  parameter int BITS     = `CLOG2(NUM),
  parameter int FWFT     = 1,
  parameter int AF_LEVEL = NUM - AF_MARGIN,
  parameter int AE_LEVEL = AE_DEFAULT
) (
  input  logic           clk,
  input  logic           reset_n,
  fifo_thresh_if.slave   bus
);

  localparam logic [BITS:0] NUM_C = (BITS+1)'(NUM);
  localparam logic [BITS:0] AF_C  = (BITS+1)'(AF_LEVEL);
  localparam logic [BITS:0] AE_C  = (BITS+1)'(AE_LEVEL);
  localparam logic [BITS-1:0] PTR_ONE = {{(BITS-1){1'b0}}, 1'b1};

  logic [BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BITS:0]    count_q, count_d;
  flags_t           flags_q, flags_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rvalid_q, rvalid_d;
  logic             shown_q, shown_d;     // a real word has reached read_data
  logic             bypass_q, bypass_d;   // head word was written on last edge
  logic [WIDTH-1:0] wdata_q, wdata_d;

  logic             wr_acc, rd_acc;
  logic             ram_re;
  logic [BITS-1:0]  ram_raddr;
  logic [WIDTH-1:0] ram_rdata;

  // Acceptance: flush discards both strobes; writing into an empty FIFO
  // never makes a same-cycle read legal.
  always_comb begin
    rd_acc = bus.read_strobe && (count_q != '0) && !bus.flush;
    wr_acc = bus.write_strobe && ((count_q != NUM_C) || rd_acc) && !bus.flush;
  end

  // Next-state pointers, count, flags and read-path bookkeeping
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wdata_d     = wdata_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        wdata_d  = bus.write_data;
      end
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + {{BITS{1'b0}}, wr_acc} - {{BITS{1'b0}}, rd_acc};
      if (bus.write_strobe && !wr_acc) overflow_d  = 1'b1;
      if (bus.read_strobe  && !rd_acc) underflow_d = 1'b1;
    end

    flags_d.full           = (count_d == NUM_C);
    flags_d.almost_full    = (count_d >= AF_C);
    flags_d.data_available = (count_d != '0);
    flags_d.almost_empty   = (count_d <= AE_C);

    // Registered-read mode pulses valid once per accepted read (zero on flush
    // because rd_acc is suppressed).
    rvalid_d = rd_acc;

    if (FWFT != 0) begin
      // Prefetch the next head every cycle; a write landing on that head
      // address is forwarded since the RAM returns the old word.
      ram_re    = 1'b1;
      ram_raddr = rd_ptr_d;
      bypass_d  = wr_acc && (wr_ptr_q == rd_ptr_d);
      shown_d   = shown_q || (count_d != '0);
    end else begin
      ram_re    = rd_acc;
      ram_raddr = rd_ptr_q;
      bypass_d  = 1'b0;
      shown_d   = shown_q || rd_acc;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flags_q     <= FLAGS_RESET;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rvalid_q    <= 1'b0;
      shown_q     <= 1'b0;
      bypass_q    <= 1'b0;
      wdata_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flags_q     <= flags_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rvalid_q    <= rvalid_d;
      shown_q     <= shown_d;
      bypass_q    <= bypass_d;
      wdata_q     <= wdata_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .NUM   (NUM),
    .BITS  (BITS)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.write_data),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign bus.full           = flags_q.full;
  assign bus.almost_full    = flags_q.almost_full;
  assign bus.data_available = flags_q.data_available;
  assign bus.almost_empty   = flags_q.almost_empty;
  assign bus.level          = count_q;
  assign bus.overflow       = overflow_q;
  assign bus.underflow      = underflow_q;
  assign bus.read_valid     = (FWFT != 0) ? flags_q.data_available : rvalid_q;
  assign bus.read_data      = !shown_q ? '0 : (bypass_q ? wdata_q : ram_rdata);

endmodule
